// File: rtl/io_irq_servicer.sv
// io_irq_servicer: bus initiator for the IO handler.
// Programs CONTROL regs, then services RX_READY ports on interrupt.
module io_irq_servicer #(
  parameter int          IO_PORTS    = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          PORT_STRIDE = 16,
  parameter int          READ_LAT    = 1,
  localparam int         PW = (IO_PORTS > 1) ? $clog2(IO_PORTS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    ctrl_init,
  input  logic [7:0]    xor_mask,
  output logic [31:0]   io_addr,
  output logic          io_read,
  output logic          io_write,
  output logic [31:0]   io_wdata,
  input  logic [31:0]   io_rdata,
  input  logic          io_irq,
  output logic          busy,
  output logic          init_done,
  output logic [15:0]   svc_count,
  output logic [PW-1:0] last_port,
  output logic [7:0]    last_data
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [PW-1:0] LAST = PW'(IO_PORTS - 1);

  localparam logic [3:0] S_INIT      = 4'd0;
  localparam logic [3:0] S_IDLE      = 4'd1;
  localparam logic [3:0] S_RD_STAT   = 4'd2;
  localparam logic [3:0] S_WAIT_STAT = 4'd3;
  localparam logic [3:0] S_RD_DATA   = 4'd4;
  localparam logic [3:0] S_WAIT_DATA = 4'd5;
  localparam logic [3:0] S_WR_OUT    = 4'd6;
  localparam logic [3:0] S_WR_CLR    = 4'd7;
  localparam logic [3:0] S_NEXT      = 4'd8;

  logic [3:0]    state;
  logic [PW-1:0] port;
  logic [CW-1:0] wcnt;
  logic [7:0]    dat;
  logic          armed;
  logic [31:0]   base;
  logic          unused_rdata;

  assign unused_rdata = ^io_rdata[31:8];
  assign base = BASE_ADDR + 32'(port) * 32'(PORT_STRIDE);
  assign busy = armed & (state != S_IDLE);

  // Bus strobes decoded from the current state; silent until armed.
  always_comb begin
    io_addr  = 32'h0;
    io_read  = 1'b0;
    io_write = 1'b0;
    io_wdata = 32'h0;
    if (armed) begin
      case (state)
        S_INIT: begin
          io_write = 1'b1;
          io_addr  = base + 32'd8;
          io_wdata = {24'h0, ctrl_init};
        end
        S_RD_STAT: begin
          io_read = 1'b1;
          io_addr = base + 32'd12;
        end
        S_RD_DATA: begin
          io_read = 1'b1;
          io_addr = base;
        end
        S_WR_OUT: begin
          io_write = 1'b1;
          io_addr  = base + 32'd4;
          io_wdata = {24'h0, dat ^ xor_mask};
        end
        S_WR_CLR: begin
          io_write = 1'b1;
          io_addr  = base + 32'd12;
          io_wdata = 32'h1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer: init, idle, per-port scan; armed holds off one cycle after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      port      <= '0;
      wcnt      <= '0;
      dat       <= 8'h0;
      armed     <= 1'b0;
      init_done <= 1'b0;
      svc_count <= 16'h0;
      last_port <= '0;
      last_data <= 8'h0;
    end else begin
      armed <= 1'b1;
      if (armed) begin
        case (state)
          S_INIT: begin
            if (port == LAST) begin
              port      <= '0;
              state     <= S_IDLE;
              init_done <= 1'b1;
            end else begin
              port <= port + 1'b1;
            end
          end
          S_IDLE: begin
            if (enable && io_irq) begin
              port  <= '0;
              state <= S_RD_STAT;
            end
          end
          S_RD_STAT: begin
            wcnt  <= CW'(READ_LAT - 1);
            state <= S_WAIT_STAT;
          end
          S_WAIT_STAT: begin
            if (wcnt != '0) wcnt <= wcnt - 1'b1;
            else state <= io_rdata[0] ? S_RD_DATA : S_NEXT;
          end
          S_RD_DATA: begin
            wcnt  <= CW'(READ_LAT - 1);
            state <= S_WAIT_DATA;
          end
          S_WAIT_DATA: begin
            if (wcnt != '0) begin
              wcnt <= wcnt - 1'b1;
            end else begin
              dat   <= io_rdata[7:0];
              state <= S_WR_OUT;
            end
          end
          S_WR_OUT: state <= S_WR_CLR;
          S_WR_CLR: begin
            if (svc_count != 16'hFFFF) svc_count <= svc_count + 16'h1;
            last_port <= port;
            last_data <= dat;
            state     <= S_NEXT;
          end
          S_NEXT: begin
            if (port == LAST) begin
              state <= S_IDLE;
            end else begin
              port  <= port + 1'b1;
              state <= S_RD_STAT;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_io_irq_servicer.sv
// tb_io_irq_servicer: handler model, bus scoreboard,
// vector table and corner-case sequences.
module tb_io_irq_servicer;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  ctrl_init, xor_mask;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_read, io_write, io_irq;
  logic        busy, init_done;
  logic [15:0] svc_count;
  logic [1:0]  last_port;
  logic [7:0]  last_data;

  always #5 clk = ~clk;

  io_irq_servicer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ctrl_init(ctrl_init), .xor_mask(xor_mask),
    .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_irq(io_irq),
    .busy(busy), .init_done(init_done), .svc_count(svc_count),
    .last_port(last_port), .last_data(last_data)
  );

  // handler model: one-cycle read latency, W1C status, junk upper bits
  logic [3:0]  stat;
  logic [7:0]  din [4];
  logic        load_req, irq_force;
  logic [3:0]  load_stat;
  logic [31:0] load_din;

  assign io_irq = (|stat) | irq_force;

  always @(posedge clk) begin
    if (load_req) begin
      stat <= load_stat;
      for (int i = 0; i < 4; i++) din[i] <= load_din[8*i +: 8];
    end else if (io_write && io_addr[3:0] == 4'hC && io_wdata[0]) begin
      stat[io_addr[5:4]] <= 1'b0;
    end
    io_rdata <= 32'h0;
    if (io_read) begin
      if (io_addr[3:0] == 4'hC)
        io_rdata <= {31'h2468ACE0, stat[io_addr[5:4]]};
      else
        io_rdata <= {24'hDEADBE, din[io_addr[5:4]]};
    end
  end

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [3:0]  ready;
    logic [31:0] din;
    logic [7:0]  mask;
  } vec_t;

  txn_t exp_q[$];
  txn_t e_mon;
  int   tests = 0;
  int   fails = 0;
  int   strobes = 0;

  int          m_svc = 0;
  logic [1:0]  m_port = 2'd0;
  logic [7:0]  m_data = 8'h0;

  // scoreboard: every strobe must match the next expected transaction
  always @(negedge clk) begin
    if (!reset && (io_read || io_write)) begin
      strobes++;
      tests++;
      if (io_read && io_write) begin
        fails++;
        $display("FAIL both_strobes addr=%h required one strobe", io_addr);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_txn wr=%0b addr=%h data=%h required none",
                 io_write, io_addr, io_wdata);
      end else begin
        e_mon = exp_q.pop_front();
        if (e_mon.wr !== io_write || e_mon.addr !== io_addr ||
            e_mon.data !== io_wdata) begin
          fails++;
          $display("FAIL bus_txn got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                   io_write, io_addr, io_wdata, e_mon.wr, e_mon.addr, e_mon.data);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_rd(logic [31:0] a);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = 32'h0;
    exp_q.push_back(t);
  endtask

  task automatic push_wr(logic [31:0] a, logic [31:0] d);
    txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic wait_empty(string name, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, {31'h0, busy}, 32'h0);
  endtask

  task automatic run_vec(vec_t v, string name);
    int n;
    logic [7:0] d;
    xor_mask = v.mask;
    for (int p = 0; p < 4; p++) begin
      push_rd(32'(p * 16 + 12));
      if (v.ready[p]) begin
        d = v.din[8*p +: 8];
        push_rd(32'(p * 16));
        push_wr(32'(p * 16 + 4), {24'h0, d ^ v.mask});
        push_wr(32'(p * 16 + 12), 32'h1);
        if (m_svc != 16'hFFFF) m_svc++;
        m_port = 2'(p);
        m_data = d;
      end
    end
    load_stat = v.ready;
    load_din  = v.din;
    load_req  = 1'b1;
    @(negedge clk); #1;
    load_req  = 1'b0;
    wait_empty({name, "_drain"}, n);
    wait_idle({name, "_idle"});
    chk({name, "_svc"}, {16'h0, svc_count}, 32'(m_svc));
    chk({name, "_port"}, {30'h0, last_port}, {30'h0, m_port});
    chk({name, "_data"}, {24'h0, last_data}, {24'h0, m_data});
  endtask

  task automatic push_init(logic [7:0] c);
    for (int p = 0; p < 4; p++) push_wr(32'(p * 16 + 8), {24'h0, c});
  endtask

  vec_t vt[5];
  vec_t v1;
  int   n, s0;

  initial begin
    vt[0] = '{ready: 4'b0100, din: 32'h003C_0000, mask: 8'hFF};
    vt[1] = '{ready: 4'b1001, din: 32'hF000_0011, mask: 8'h0F};
    vt[2] = '{ready: 4'b1111, din: 32'h0403_0201, mask: 8'h00};
    vt[3] = '{ready: 4'b0010, din: 32'h0000_AA00, mask: 8'h55};
    vt[4] = '{ready: 4'b0001, din: 32'h0000_0080, mask: 8'h81};

    reset = 1'b1; enable = 1'b0; ctrl_init = 8'hA5; xor_mask = 8'h0;
    irq_force = 1'b0; load_req = 1'b1; load_stat = 4'h0; load_din = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read", {31'h0, io_read}, 32'h0);
    chk("rst_write", {31'h0, io_write}, 32'h0);
    chk("rst_addr", io_addr, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_svc", {16'h0, svc_count}, 32'h0);
    load_req = 1'b0;

    // T1: init writes on four consecutive cycles, then init_done
    push_init(8'hA5);
    reset = 1'b0;
    wait_empty("t1_init", n);
    chk("t1_init_cycles", 32'(n), 32'd4);
    chk("t1_init_done_lo", {31'h0, init_done}, 32'h0);
    @(negedge clk); #1;
    chk("t1_init_done_hi", {31'h0, init_done}, 32'h1);
    chk("t1_busy", {31'h0, busy}, 32'h0);

    // T2 and table vectors
    enable = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // T3: irq with nothing ready, two full scans of status reads
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) push_rd(32'(p * 16 + 12));
    irq_force = 1'b1;
    wait_empty("t3_rescan", n);
    irq_force = 1'b0;
    wait_idle("t3_idle");
    chk("t3_svc", {16'h0, svc_count}, 32'(m_svc));

    // T4: irq held with enable low, then enable starts a scan
    enable = 1'b0;
    irq_force = 1'b1;
    s0 = strobes;
    repeat (10) @(negedge clk);
    #1;
    chk("t4_quiet", 32'(strobes - s0), 32'h0);
    for (int p = 0; p < 4; p++) push_rd(32'(p * 16 + 12));
    enable = 1'b1;
    @(negedge clk); #1;
    chk("t4_start_rd", {31'h0, io_read}, 32'h1);
    chk("t4_start_addr", io_addr, 32'h0000_000C);
    irq_force = 1'b0;
    wait_empty("t4_scan", n);
    wait_idle("t4_idle");

    // T5: reset in WAIT_DATA aborts and re-runs init
    push_rd(32'h0C); push_rd(32'h1C); push_rd(32'h10);
    load_stat = 4'b0010; load_din = 32'h0000_7700; load_req = 1'b1;
    @(negedge clk); #1;
    load_req = 1'b0;
    wait_empty("t5_reach", n);
    @(negedge clk); #1;
    chk("t5_busy_wait", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    load_stat = 4'h0; load_req = 1'b1; ctrl_init = 8'h3C;
    @(negedge clk); #1;
    chk("t5_read", {31'h0, io_read}, 32'h0);
    chk("t5_write", {31'h0, io_write}, 32'h0);
    chk("t5_svc", {16'h0, svc_count}, 32'h0);
    chk("t5_init_done", {31'h0, init_done}, 32'h0);
    chk("t5_last_data", {24'h0, last_data}, 32'h0);
    load_req = 1'b0;
    m_svc = 0; m_port = 2'd0; m_data = 8'h0;
    push_init(8'h3C);
    reset = 1'b0;
    wait_empty("t5_init", n);
    chk("t5_init_cycles", 32'(n), 32'd4);
    @(negedge clk); #1;
    chk("t5_init_done_hi", {31'h0, init_done}, 32'h1);

    // T6: saturation of the service counter
    force dut.svc_count = 16'hFFFE;
    @(negedge clk); #1;
    release dut.svc_count;
    @(negedge clk); #1;
    chk("t6_preload", {16'h0, svc_count}, 32'h0000_FFFE);
    m_svc = 16'hFFFE;
    v1 = '{ready: 4'b0001, din: 32'h0000_005A, mask: 8'h00};
    run_vec(v1, "t6_a");
    v1 = '{ready: 4'b1000, din: 32'hC700_0000, mask: 8'h11};
    run_vec(v1, "t6_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout required finish");
    $fatal(1);
  end

endmodule
